// File: rtl/adder_share_if.sv
// adder_share_if: request/response bundle between arithmetic clients and adder_share_arbiter
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_a/req_b         : 64-bit operands, requester i at [64*i+63:64*i]
//   rsp_valid/rsp_ready : result handshake
//   rsp_s/rsp_id        : 65-bit sum (bit 64 = carry-out) and issuing requester index
interface adder_share_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [64*NREQ-1:0] req_a;
    logic [64*NREQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [64:0]        rsp_s;
    logic [IDW-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_id
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one Brent-Kung 64-bit adder among NREQ requesters
//   clk, rst  : clock, synchronous active-high reset
//   bus       : adder_share_if slave (requests in, tagged 65-bit results out)
//   op_count  : number of delivered results, wraps
//   busy      : either pipeline stage holds valid data
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    adder_share_if.slave    bus,
    output logic [CNTW-1:0] op_count,
    output logic            busy
);
    // Brent-Kung prefix adder: up-sweep builds power-of-two group carries,
    // down-sweep fills in the remaining prefixes from those groups.
    function automatic logic [64:0] bk_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] g;
        logic [63:0] p;
        logic [63:0] x;
        g = a & b;
        p = a ^ b;
        x = p;
        for (int l = 1; l <= 6; l++) begin
            for (int i = (1 << l) - 1; i < 64; i += (1 << l)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << (l - 1))]);
                p[i] = p[i] & p[i - (1 << (l - 1))];
            end
        end
        for (int l = 5; l >= 1; l--) begin
            for (int i = (1 << l) + (1 << (l - 1)) - 1; i < 64; i += (1 << l)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << (l - 1))]);
                p[i] = p[i] & p[i - (1 << (l - 1))];
            end
        end
        return {g[63], x ^ {g[62:0], 1'b0}};
    endfunction

    logic            op_v;
    logic [63:0]     op_a;
    logic [63:0]     op_b;
    logic [IDW-1:0]  op_id;
    logic            res_v;
    logic [64:0]     res_s;
    logic [IDW-1:0]  res_id;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  nxt_ptr;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [NREQ-1:0] grant;
    logic [63:0]     sel_a;
    logic [63:0]     sel_b;
    logic [64:0]     sum;
    logic            res_adv;
    logic            op_adv;
    logic            accept;
    int              best;

    assign res_adv = ~res_v | bus.rsp_ready;
    assign op_adv  = ~op_v | res_adv;

    // Requester with the smallest cyclic distance from ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        nxt_ptr = ptr;
        best    = NREQ;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && ((i + NREQ - int'(ptr)) % NREQ) < best) begin
                best    = (i + NREQ - int'(ptr)) % NREQ;
                gnt_any = 1'b1;
                gnt_idx = IDW'(i);
                nxt_ptr = IDW'((i + 1) % NREQ);
                sel_a   = bus.req_a[64*i +: 64];
                sel_b   = bus.req_b[64*i +: 64];
            end
        end
    end

    assign grant         = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    assign bus.req_ready = (rst || !op_adv) ? '0 : grant;
    assign accept        = gnt_any & op_adv;
    assign sum           = bk_add(op_a, op_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_v     <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
            res_v    <= 1'b0;
            res_s    <= '0;
            res_id   <= '0;
            ptr      <= '0;
            op_count <= '0;
        end else begin
            if (res_adv) begin
                res_v <= op_v;
                if (op_v) begin
                    res_s  <= sum;
                    res_id <= op_id;
                end
            end
            if (op_adv) begin
                op_v <= accept;
                if (accept) begin
                    op_a  <= sel_a;
                    op_b  <= sel_b;
                    op_id <= gnt_idx;
                    ptr   <= nxt_ptr;
                end
            end
            if (res_v && bus.rsp_ready)
                op_count <= op_count + 1'b1;
        end
    end

    assign bus.rsp_valid = res_v;
    assign bus.rsp_s     = res_s;
    assign bus.rsp_id    = res_id;
    assign busy          = op_v | res_v;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and soak checks of adder_share_arbiter
module tb_adder_share_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] op_count;
    logic        busy;
    logic [63:0] a_arr [4];
    logic [63:0] b_arr [4];
    int          total = 0;
    int          bad = 0;
    logic [64:0] q [4][$];
    int          n_rsp = 0;
    logic [3:0]  acc;
    logic [64:0] e;

    adder_share_if #(.NREQ(4), .IDW(2)) bus ();

    adder_share_arbiter #(.NREQ(4), .IDW(2), .CNTW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .op_count (op_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.req_a[64*i +: 64] = a_arr[i];
            bus.req_b[64*i +: 64] = b_arr[i];
        end
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard sampling point: inputs settled, before the next rising edge.
    task automatic sample;
        acc = bus.req_valid & bus.req_ready;
        for (int i = 0; i < 4; i++)
            if (acc[i]) q[i].push_back({1'b0, a_arr[i]} + {1'b0, b_arr[i]});
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_rsp++;
            check("soak_rsp_expected", 65'(q[bus.rsp_id].size() != 0), 65'd1);
            if (q[bus.rsp_id].size() != 0) begin
                e = q[bus.rsp_id].pop_front();
                check("soak_sum", bus.rsp_s, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        @(negedge clk);
        step;
        step;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_s", bus.rsp_s, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // single op from requester 2
        a_arr[2] = 64'd5;
        b_arr[2] = 64'd7;
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        #1;
        check("single_req_ready", bus.req_ready, 4'b0100);
        step;
        bus.req_valid = '0;
        check("single_mid_rsp_valid", bus.rsp_valid, 0);
        check("single_mid_busy", busy, 1);
        step;
        check("single_rsp_valid", bus.rsp_valid, 1);
        check("single_rsp_s", bus.rsp_s, 65'd12);
        check("single_rsp_id", bus.rsp_id, 2);
        step;
        check("single_op_count", op_count, 1);
        check("single_idle_busy", busy, 0);

        // carry-out: max + 1 on requester 1
        a_arr[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        b_arr[1] = 64'd1;
        bus.req_valid = 4'b0010;
        #1;
        check("carry1_req_ready", bus.req_ready, 4'b0010);
        step;
        bus.req_valid = '0;
        step;
        check("carry1_rsp_s", bus.rsp_s, 65'h1_0000_0000_0000_0000);
        check("carry1_rsp_id", bus.rsp_id, 1);
        step;

        // carry-out: max + max on requester 3
        a_arr[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        b_arr[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.req_valid = 4'b1000;
        step;
        bus.req_valid = '0;
        step;
        check("carry2_rsp_s", bus.rsp_s, 65'h1_FFFF_FFFF_FFFF_FFFE);
        check("carry2_rsp_id", bus.rsp_id, 3);
        step;
        check("carry_op_count", op_count, 3);

        // round robin with everyone requesting, pointer at 0
        a_arr = '{64'd100, 64'd200, 64'd300, 64'd400};
        b_arr = '{64'd1, 64'd2, 64'd3, 64'd4};
        bus.req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            #1;
            check($sformatf("rr_grant_%0d", j), bus.req_ready, 4'b0001 << (j % 4));
            if (j >= 2) begin
                check($sformatf("rr_rsp_valid_%0d", j), bus.rsp_valid, 1);
                check($sformatf("rr_rsp_id_%0d", j), bus.rsp_id, (j - 2) % 4);
                check($sformatf("rr_rsp_s_%0d", j), bus.rsp_s, 65'(101 * ((j - 2) % 4 + 1)));
            end
            step;
        end
        bus.req_valid = '0;
        check("rr_tail_id2", bus.rsp_id, 2);
        check("rr_tail_s2", bus.rsp_s, 65'd303);
        step;
        check("rr_tail_id3", bus.rsp_id, 3);
        check("rr_tail_s3", bus.rsp_s, 65'd404);
        step;
        check("rr_busy", busy, 0);
        check("rr_op_count", op_count, 11);

        // backpressure: 5 cycles stalled, continuous requests
        begin
            int n_acc;
            n_acc = 0;
            bus.req_valid = 4'b1111;
            bus.rsp_ready = 1'b0;
            for (int j = 0; j < 5; j++) begin
                #1;
                if (|bus.req_ready) n_acc++;
                if (j >= 2) begin
                    check($sformatf("bp_req_ready_%0d", j), bus.req_ready, 0);
                    check($sformatf("bp_rsp_valid_%0d", j), bus.rsp_valid, 1);
                    check($sformatf("bp_rsp_id_%0d", j), bus.rsp_id, 0);
                    check($sformatf("bp_rsp_s_%0d", j), bus.rsp_s, 65'd101);
                end
                step;
            end
            check("bp_accepted", n_acc, 2);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_rel_id0", bus.rsp_id, 0);
        check("bp_rel_s0", bus.rsp_s, 65'd101);
        step;
        check("bp_rel_valid1", bus.rsp_valid, 1);
        check("bp_rel_id1", bus.rsp_id, 1);
        check("bp_rel_s1", bus.rsp_s, 65'd202);
        step;
        check("bp_rel_empty", bus.rsp_valid, 0);
        check("bp_op_count", op_count, 13);

        // reset with both stages full
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b0;
        step;
        step;
        check("rmf_busy", busy, 1);
        check("rmf_rsp_id", bus.rsp_id, 2);
        rst = 1'b1;
        #1;
        check("rmf_req_ready_in_rst", bus.req_ready, 0);
        step;
        rst = 1'b0;
        #1;
        check("rmf_rsp_valid", bus.rsp_valid, 0);
        check("rmf_busy_after", busy, 0);
        check("rmf_op_count", op_count, 0);
        check("rmf_grant0", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        step;

        // random soak with per-requester ordered scoreboard
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i] || !bus.req_valid[i]) begin
                    bus.req_valid[i] = ($urandom_range(3) != 0);
                    a_arr[i] = ($urandom_range(15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
                    b_arr[i] = {$urandom, $urandom};
                end
            end
            bus.rsp_ready = ($urandom_range(2) != 0);
            #1;
            sample;
            step;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            sample;
            step;
        end
        check("soak_op_count", op_count, 32'(n_rsp));
        check("soak_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        check("soak_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
